fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Y86-64 pipeline front end: selects the fetch PC, reads one 10-byte instruction window,
//  splits it into icode/ifun/rA/rB/valC and computes valP and the predicted next PC.
//  Owns the F register (predPC) and the F->D pipeline register, so it is the producer
//  of the D_* fields that the decode/write-back stage consumes.
// PARAMETERS
//  RESET_PC   64'h0   value loaded into F_predPC on reset
// PORTS
//  clk_i         in   1    clock; all state updates on posedge
//  rstn_i        in   1    reset, asynchronous, active-low
//  imem_addr_o   out  64   fetch address (f_pc), combinational
//  imem_data_i   in   80   bytes f_pc..f_pc+9; byte k = [8k+7:8k]
//  imem_err_i    in   1    address invalid for this fetch
//  M_icode_i     in   4    icode in M stage
//  M_cnd_i       in   1    branch condition of M-stage jump
//  M_valA_i      in   64   fall-through PC carried by the M-stage jump
//  W_icode_i     in   4    icode in W stage
//  W_valM_i      in   64   return address popped by the W-stage ret
//  F_stall_i     in   1    hold F_predPC
//  D_stall_i     in   1    hold D register
//  D_bubble_i    in   1    load NOP bubble into D register
//  D_stat_o      out  4    registered status (AOK/HLT/ADR/INS)
//  D_icode_o     out  4    registered icode
//  D_ifun_o      out  4    registered ifun
//  D_rA_o        out  4    registered rA (RNONE when absent)
//  D_rB_o        out  4    registered rB (RNONE when absent)
//  D_valC_o      out  64   registered constant (0 when absent)
//  D_valP_o      out  64   registered address of next sequential instruction
// BEHAVIOUR
//  - PC select (priority): M_icode==IJXX && !M_cnd -> M_valA; else W_icode==IRET -> W_valM;
//    else F_predPC. imem_addr_o = f_pc.
//  - Byte0 = {icode[7:4], ifun[3:0]}; byte1 = {rA[7:4], rB[3:0]}; valC little-endian.
//  - need_regids: ICMOVQ,IIRMOVQ,IRMMOVQ,IMRMOVQ,IOPQ,IPUSHQ,IPOPQ.
//    need_valC: IIRMOVQ,IRMMOVQ,IMRMOVQ,IJXX,ICALL. valC from byte 2 if need_regids else byte 1.
//  - valP = f_pc + 1 + need_regids + 8*need_valC, 64-bit modulo (wraps, no flag).
//  - Absent fields: rA=rB=RNONE, valC=0.
//  - imem_err_i: icode=INOP, ifun=0, stat=ADR. Else icode>IPOPQ: stat=INS.
//    Else icode==IHALT: stat=HLT. Else AOK. ADR outranks INS outranks HLT.
//  - f_predPC = valC for IJXX/ICALL, else valP.
//  - F register: load f_predPC each posedge unless F_stall_i.
//  - D register per posedge: D_stall_i -> hold; else D_bubble_i -> bubble;
//    else load fetched fields. Stall wins over bubble when both asserted.
//  - Bubble/reset value: stat=AOK, icode=INOP, ifun=0, rA=rB=RNONE, valC=0, valP=0.
//  - Reset (async, any cycle): F_predPC=RESET_PC, D reg = bubble; first fetch after
//    release is at RESET_PC. Latency: fetched instruction visible on D_* 1 cycle later.
//  - Mispredict and ret redirect simultaneously: mispredict path wins (older instr).
// STRUCTURE
//  - define.v holds icode (IHALT..IPOPQ), RNONE/RRSP, stat codes (SAOK=1,SHLT=2,SADR=3,
//    SINS=4), NIBBLE/BYTE/D_WORD ranges; no new local copies of these.
//  - One combinational sub-module fetch_align: byte window -> fields, need_*, valP,
//    predPC, stat. Top holds PC select, F and D registers.
// TESTING
//  - Reset: rstn_i low mid-run -> D_icode=INOP, D_rA=RNONE immediately; imem_addr_o=RESET_PC.
//  - irmovq 0x1122334455667788,%rbx at 0 -> D_icode=3, rB=3, rA=RNONE, valC=0x1122334455667788, valP=10.
//  - jxx to 0x40 at 0x10 -> predPC 0x40; later M_icode=7,M_cnd=0,M_valA=0x19 -> imem_addr_o=0x19.
//  - ret at 0x20, W_icode=9, W_valM=0x88 -> imem_addr_o=0x88; both redirects -> M_valA chosen.
//  - D_stall and D_bubble together -> D held; D_bubble alone -> NOP bubble; F_stall -> addr held.
//  - imem_err_i=1 -> D_stat=ADR, icode=INOP; byte0=0xC0 -> D_stat=INS; byte0=0x00 -> HLT.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared Y86-64 front-end definitions: instruction codes, register ids,
// status codes, field widths and the F->D register layout.
package fetch_stage_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int BYTE_W     = 8;
  localparam int D_WORD_W   = 64;
  localparam int IWIN_BYTES = 10;
  localparam int IWIN_W     = IWIN_BYTES * BYTE_W;

  // Instruction codes
  localparam logic [NIBBLE_W-1:0] IHALT   = 4'h0;
  localparam logic [NIBBLE_W-1:0] INOP    = 4'h1;
  localparam logic [NIBBLE_W-1:0] ICMOVQ  = 4'h2;
  localparam logic [NIBBLE_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [NIBBLE_W-1:0] IRMMOVQ = 4'h4;
  localparam logic [NIBBLE_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [NIBBLE_W-1:0] IOPQ    = 4'h6;
  localparam logic [NIBBLE_W-1:0] IJXX    = 4'h7;
  localparam logic [NIBBLE_W-1:0] ICALL   = 4'h8;
  localparam logic [NIBBLE_W-1:0] IRET    = 4'h9;
  localparam logic [NIBBLE_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [NIBBLE_W-1:0] IPOPQ   = 4'hB;

  // Register ids
  localparam logic [NIBBLE_W-1:0] RRSP  = 4'h4;
  localparam logic [NIBBLE_W-1:0] RNONE = 4'hF;

  // Status codes
  localparam logic [NIBBLE_W-1:0] SAOK = 4'h1;
  localparam logic [NIBBLE_W-1:0] SHLT = 4'h2;
  localparam logic [NIBBLE_W-1:0] SADR = 4'h3;
  localparam logic [NIBBLE_W-1:0] SINS = 4'h4;

  // Contents of the F->D pipeline register
  typedef struct packed {
    logic [NIBBLE_W-1:0] stat;
    logic [NIBBLE_W-1:0] icode;
    logic [NIBBLE_W-1:0] ifun;
    logic [NIBBLE_W-1:0] ra;
    logic [NIBBLE_W-1:0] rb;
    logic [D_WORD_W-1:0] valc;
    logic [D_WORD_W-1:0] valp;
  } d_reg_t;

  // Reset and bubble value: a NOP that carries no operands
  localparam d_reg_t D_BUBBLE = '{
    stat:  SAOK,
    icode: INOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  64'h0,
    valp:  64'h0
  };

  // Instruction carries the rA:rB byte
  function automatic logic need_regids(input logic [NIBBLE_W-1:0] icode);
    return (icode == ICMOVQ)  || (icode == IIRMOVQ) || (icode == IRMMOVQ) ||
           (icode == IMRMOVQ) || (icode == IOPQ)    || (icode == IPUSHQ)  ||
           (icode == IPOPQ);
  endfunction

  // Instruction carries an 8-byte constant
  function automatic logic need_valc(input logic [NIBBLE_W-1:0] icode);
    return (icode == IIRMOVQ) || (icode == IRMMOVQ) || (icode == IMRMOVQ) ||
           (icode == IJXX)    || (icode == ICALL);
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational instruction splitter: 10-byte window at f_pc -> decoded
// fields, status, next sequential PC and predicted next PC.
module fetch_align
  import fetch_stage_pkg::*;
(
  input  logic [D_WORD_W-1:0] pc,
  input  logic [IWIN_W-1:0]   win,
  input  logic                imem_err,
  output d_reg_t              fetched,
  output logic [D_WORD_W-1:0] pred_pc
);

  logic [BYTE_W-1:0]   byte0;
  logic [BYTE_W-1:0]   byte1;
  logic [NIBBLE_W-1:0] icode;
  logic                nr;
  logic                nc;
  logic [D_WORD_W-1:0] valc;
  logic [D_WORD_W-1:0] valp;

  // Field extraction; a bad fetch address is turned into a NOP so the
  // downstream stages see nothing but the ADR status.
  always_comb begin
    byte0 = win[0*BYTE_W +: BYTE_W];
    byte1 = win[1*BYTE_W +: BYTE_W];
    icode = imem_err ? INOP : byte0[7:4];
    nr    = need_regids(icode);
    nc    = need_valc(icode);

    valc = '0;
    if (nc) valc = nr ? win[2*BYTE_W +: D_WORD_W] : win[1*BYTE_W +: D_WORD_W];

    // 64-bit modulo on purpose: a fetch near the top of memory wraps
    valp = pc + 64'd1 + {63'd0, nr} + (nc ? 64'd8 : 64'd0);

    fetched.icode = icode;
    fetched.ifun  = imem_err ? 4'h0 : byte0[3:0];
    fetched.ra    = nr ? byte1[7:4] : RNONE;
    fetched.rb    = nr ? byte1[3:0] : RNONE;
    fetched.valc  = valc;
    fetched.valp  = valp;

    // ADR outranks INS outranks HLT
    if (imem_err)            fetched.stat = SADR;
    else if (icode > IPOPQ)  fetched.stat = SINS;
    else if (icode == IHALT) fetched.stat = SHLT;
    else                     fetched.stat = SAOK;

    // Jumps are predicted taken; calls always go to their target
    pred_pc = ((icode == IJXX) || (icode == ICALL)) ? valc : valp;
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, F register (predicted PC) and the F->D
// pipeline register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  output logic [63:0]        imem_addr_o,
  input  logic [79:0]        imem_data_i,
  input  logic               imem_err_i,
  input  logic [3:0]         M_icode_i,
  input  logic               M_cnd_i,
  input  logic [63:0]        M_valA_i,
  input  logic [3:0]         W_icode_i,
  input  logic [63:0]        W_valM_i,
  input  logic               F_stall_i,
  input  logic               D_stall_i,
  input  logic               D_bubble_i,
  output logic [3:0]         D_stat_o,
  output logic [3:0]         D_icode_o,
  output logic [3:0]         D_ifun_o,
  output logic [3:0]         D_rA_o,
  output logic [3:0]         D_rB_o,
  output logic [63:0]        D_valC_o,
  output logic [63:0]        D_valP_o
);

  logic [63:0] f_predpc_q;
  logic [63:0] f_pc;
  logic [63:0] f_predpc;
  d_reg_t      fetched;
  d_reg_t      d_q;

  // PC select: the mispredicted jump is older than the ret, so it wins
  always_comb begin
    if ((M_icode_i == IJXX) && !M_cnd_i) f_pc = M_valA_i;
    else if (W_icode_i == IRET)          f_pc = W_valM_i;
    else                                 f_pc = f_predpc_q;
  end

  assign imem_addr_o = f_pc;

  fetch_align u_align (
    .pc       (f_pc),
    .win      (imem_data_i),
    .imem_err (imem_err_i),
    .fetched  (fetched),
    .pred_pc  (f_predpc)
  );

  // F register: predicted PC, frozen while fetch is stalled
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)         f_predpc_q <= RESET_PC;
    else if (!F_stall_i) f_predpc_q <= f_predpc;
  end

  // D register: stall holds and takes precedence over bubble
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)          d_q <= D_BUBBLE;
    else if (D_stall_i)   d_q <= d_q;
    else if (D_bubble_i)  d_q <= D_BUBBLE;
    else                  d_q <= fetched;
  end

  assign D_stat_o  = d_q.stat;
  assign D_icode_o = d_q.icode;
  assign D_ifun_o  = d_q.ifun;
  assign D_rA_o    = d_q.ra;
  assign D_rB_o    = d_q.rb;
  assign D_valC_o  = d_q.valc;
  assign D_valP_o  = d_q.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a byte-array instruction memory, a
// reference decoder and a queue of expected D-register contents.
module tb_fetch_stage;

  logic        clk;
  logic        rstn;
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic        imem_err;
  logic [3:0]  m_icode;
  logic        m_cnd;
  logic [63:0] m_vala;
  logic [3:0]  w_icode;
  logic [63:0] w_valm;
  logic        f_stall;
  logic        d_stall;
  logic        d_bubble;
  logic [3:0]  d_stat, d_icode, d_ifun, d_ra, d_rb;
  logic [63:0] d_valc, d_valp;

  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .imem_addr_o (imem_addr),
    .imem_data_i (imem_data),
    .imem_err_i  (imem_err),
    .M_icode_i   (m_icode),
    .M_cnd_i     (m_cnd),
    .M_valA_i    (m_vala),
    .W_icode_i   (w_icode),
    .W_valM_i    (w_valm),
    .F_stall_i   (f_stall),
    .D_stall_i   (d_stall),
    .D_bubble_i  (d_bubble),
    .D_stat_o    (d_stat),
    .D_icode_o   (d_icode),
    .D_ifun_o    (d_ifun),
    .D_rA_o      (d_ra),
    .D_rB_o      (d_rb),
    .D_valC_o    (d_valc),
    .D_valP_o    (d_valp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256-byte memory aliased across the whole address space
  logic [7:0] mem [256];

  always_comb begin
    logic [7:0] a;
    imem_data = '0;
    for (int k = 0; k < 10; k++) begin
      a = imem_addr[7:0] + 8'(k);
      imem_data[8*k +: 8] = mem[a];
    end
  end

  typedef struct {
    logic [3:0]  stat, icode, ifun, ra, rb;
    logic [63:0] valc, valp;
  } dexp_t;

  int checks   = 0;
  int failures = 0;
  dexp_t       sbq[$];
  dexp_t       exp_d;
  logic [63:0] m_pred;
  dexp_t       bubble;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference decode of the instruction at pc
  function automatic dexp_t ref_fetch(input logic [63:0] pc, input logic err,
                                      output logic [63:0] pred);
    dexp_t e;
    logic [7:0] p, b0, b1, base;
    logic hasr, hasc;
    p  = pc[7:0];
    b0 = mem[p];
    b1 = mem[p + 8'd1];
    e.icode = err ? 4'h1 : b0[7:4];
    e.ifun  = err ? 4'h0 : b0[3:0];
    hasr = e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    hasc = e.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    e.ra = hasr ? b1[7:4] : 4'hF;
    e.rb = hasr ? b1[3:0] : 4'hF;
    e.valc = 64'h0;
    if (hasc) begin
      base = p + (hasr ? 8'd2 : 8'd1);
      for (int k = 7; k >= 0; k--) e.valc = {e.valc[55:0], mem[base + 8'(k)]};
    end
    e.valp = pc + (hasr ? 64'd2 : 64'd1) + (hasc ? 64'd8 : 64'd0);
    if (err)                 e.stat = 4'h3;
    else if (e.icode > 4'hB) e.stat = 4'h4;
    else if (e.icode == 4'h0) e.stat = 4'h2;
    else                     e.stat = 4'h1;
    pred = (e.icode == 4'h7 || e.icode == 4'h8) ? e.valc : e.valp;
    return e;
  endfunction

  // One cycle: called at negedge with inputs set; checks address,
  // pushes the expectation, compares D after the next posedge.
  task automatic step(input string tag);
    logic [63:0] epc, pred;
    dexp_t e, g;
    #1;
    if (m_icode == 4'h7 && !m_cnd) epc = m_vala;
    else if (w_icode == 4'h9)      epc = w_valm;
    else                           epc = m_pred;
    chk({tag, ".addr"}, imem_addr, epc);
    e = ref_fetch(epc, imem_err, pred);
    if (!f_stall) m_pred = pred;
    if (!d_stall) exp_d = d_bubble ? bubble : e;
    sbq.push_back(exp_d);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk({tag, ".stat"},  {60'd0, d_stat},  {60'd0, g.stat});
    chk({tag, ".icode"}, {60'd0, d_icode}, {60'd0, g.icode});
    chk({tag, ".ifun"},  {60'd0, d_ifun},  {60'd0, g.ifun});
    chk({tag, ".rA"},    {60'd0, d_ra},    {60'd0, g.ra});
    chk({tag, ".rB"},    {60'd0, d_rb},    {60'd0, g.rb});
    chk({tag, ".valC"},  d_valc, g.valc);
    chk({tag, ".valP"},  d_valp, g.valp);
    @(negedge clk);
  endtask

  task automatic idle_ctl();
    m_icode = 4'h0; m_cnd = 1'b0; m_vala = '0;
    w_icode = 4'h0; w_valm = '0;
    f_stall = 1'b0; d_stall = 1'b0; d_bubble = 1'b0; imem_err = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".icode"}, {60'd0, d_icode}, 64'h1);
    chk({tag, ".rA"},    {60'd0, d_ra},    64'hF);
    chk({tag, ".stat"},  {60'd0, d_stat},  64'h1);
    chk({tag, ".valP"},  d_valp,           64'h0);
    chk({tag, ".addr"},  imem_addr,        64'h0);
  endtask

  initial begin
    bubble = '{stat: 4'h1, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
               valc: 64'h0, valp: 64'h0};
    for (int i = 0; i < 256; i++) mem[i] = 8'h10;
    // 0x00 irmovq $0x1122334455667788,%rbx
    mem[8'h00] = 8'h30; mem[8'h01] = 8'hF3;
    for (int k = 0; k < 8; k++) mem[2 + k] = 8'(8'h88 - 8'(k * 8'h11));
    // 0x0A addq %rdx,%rbx
    mem[8'h0A] = 8'h60; mem[8'h0B] = 8'h23;
    // 0x10 jmp 0x40
    mem[8'h10] = 8'h70; mem[8'h11] = 8'h40;
    for (int k = 0; k < 7; k++) mem[8'h12 + k] = 8'h00;
    // 0x20 ret
    mem[8'h20] = 8'h90;
    // 0x30 halt, 0x31 invalid opcode
    mem[8'h30] = 8'h00; mem[8'h31] = 8'hC0;
    // 0x40 rmmovq %rcx,0x100(%rdx)
    mem[8'h40] = 8'h40; mem[8'h41] = 8'h12;
    for (int k = 0; k < 8; k++) mem[8'h42 + k] = 8'h00;
    mem[8'h43] = 8'h01;
    // 0x88 popq %rbx
    mem[8'h88] = 8'hB0; mem[8'h89] = 8'h3F;

    idle_ctl();
    rstn   = 1'b0;
    m_pred = 64'h0;
    exp_d  = bubble;
    @(negedge clk); @(negedge clk);
    chk_reset_state("rst");
    rstn = 1'b1;

    step("irmovq");
    step("addq");
    for (int i = 0; i < 4; i++) step("nop");
    step("jxx");
    step("rmmovq");
    m_icode = 4'h7; m_cnd = 1'b0; m_vala = 64'h19;
    step("mispredict");
    idle_ctl();
    for (int i = 0; i < 6; i++) step("nop2");
    step("ret");
    w_icode = 4'h9; w_valm = 64'h88;
    step("ret_redirect");
    m_icode = 4'h7; m_cnd = 1'b0; m_vala = 64'h30;
    step("both_redirect");
    idle_ctl();
    f_stall = 1'b1;
    step("f_stall");
    f_stall = 1'b0;
    step("after_fstall");
    d_stall = 1'b1; d_bubble = 1'b1;
    step("d_stall_bubble");
    d_stall = 1'b0;
    step("d_bubble");
    d_bubble = 1'b0; imem_err = 1'b1;
    step("imem_err");
    imem_err = 1'b0;
    m_icode = 4'h7; m_cnd = 1'b0; m_vala = 64'hFFFF_FFFF_FFFF_FFFF;
    step("valp_wrap");
    idle_ctl();
    step("after_wrap");
    step("addq2");

    // asynchronous reset in the middle of a cycle
    #2 rstn = 1'b0;
    m_pred = 64'h0;
    exp_d  = bubble;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rstn = 1'b1;
    step("post_rst");

    if (sbq.size() != 0) chk("sbq_empty", 64'(sbq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
